mon_exp_sched: RTL and testbench
================================

MON_EXP_SCHED -- requirements
Module: mon_exp_sched

Interface
REQ-001 SHALL have parameter bitLen, default 64, operand width in bits.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, engine watchdog limit in clock cycles (used only under REQ-032).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports req0_valid, req1_valid  input  1 each  requester N has an operation pending.
REQ-006 SHALL have ports req0_ready, req1_ready  output  1 each  scheduler accepts requester N this cycle.
REQ-007 SHALL have ports reqN_M_bar, reqN_x_bar, reqN_e, reqN_n (N=0,1)  input  bitLen each  operands of requester N.
REQ-008 SHALL have port rsp_valid  output  1  result available.
REQ-009 SHALL have port rsp_ready  input  1  consumer takes result.
REQ-010 SHALL have port rsp_id  output  1  index of requester owning the result.
REQ-011 SHALL have port rsp_ans  output  bitLen+1  captured engine result.
REQ-012 SHALL have port rsp_err  output  1  result invalid (watchdog expiry).
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have ports eng_start  output  1; eng_M_bar, eng_x_bar, eng_e, eng_n  output  bitLen each  drive the shared exponentiation engine.
REQ-015 SHALL have ports eng_stop  input  1; eng_ans  input  bitLen+1  engine completion and result.

Function
REQ-016 SHALL implement states IDLE, RUN, RESP.
REQ-017 In IDLE, reqN_ready SHALL be high only for the granted requester; the other ready SHALL be low; both low in RUN and RESP.
REQ-018 Grant SHALL be round-robin: if both valid, grant the requester not granted last; if one valid, grant it.
REQ-019 Accept on reqN_valid && reqN_ready: operands SHALL be registered into eng_* outputs, owner id stored, last-grant pointer updated, state to RUN on that edge.
REQ-020 eng_start SHALL be registered, high throughout RUN, low in IDLE and RESP; eng_* operands SHALL stay stable from accept until leaving RESP.
REQ-021 Completion SHALL be a rising edge of eng_stop (high now, low on previous sampled cycle) seen while in RUN; a level-high eng_stop at RUN entry SHALL NOT count.
REQ-022 On completion: eng_ans captured into rsp_ans, rsp_err=0, rsp_valid high from the next cycle, state to RESP.
REQ-023 In RESP, rsp_valid, rsp_id, rsp_ans, rsp_err SHALL hold until rsp_valid && rsp_ready; then rsp_valid low and state to IDLE next edge.
REQ-024 A new request SHALL NOT be accepted in the same cycle the response handshake completes (minimum one IDLE cycle).
REQ-025 Accept-to-eng_start latency SHALL be 1 cycle; eng_stop rising edge to rsp_valid SHALL be 1 cycle.
REQ-026 Requests arriving while busy SHALL wait; reqN_valid withdrawn before acceptance SHALL be ignored without error.

Reset
REQ-027 On rst_n low, immediately: state IDLE, eng_start=0, rsp_valid=0, rsp_err=0, busy=0, reqN_ready=0 until release, rsp_id=0, rsp_ans=0, eng_* operands=0.
REQ-028 Last-grant pointer SHALL reset to 1 so requester 0 wins the first contention.
REQ-029 Reset mid-RUN or mid-RESP SHALL discard the operation with no response issued.
REQ-030 Reset release SHALL be synchronous to clk; the first accept is possible on the first edge after release.

Configuration
REQ-031 Macro MON_EXP_SCHED_TIMEOUT_EN SHALL select the watchdog.
REQ-032 With macro defined: a counter SHALL clear at RUN entry and increment each RUN cycle; reaching TIMEOUT_CYCLES without completion SHALL drop eng_start, set rsp_ans=0, rsp_err=1, enter RESP.
REQ-033 Without macro: no counter, rsp_err tied 0, RUN waits indefinitely for eng_stop.

Verification
REQ-034 Single op: req0 M_bar=26, x_bar=157, n=589, e=5; model asserts eng_stop after 20 cycles with ans=311 -> eng_start 1 cycle after accept, rsp_valid next cycle after stop, rsp_id=0, rsp_ans=311, rsp_err=0.
REQ-035 Contention: req0 and req1 valid in same cycle, three ops each -> grant order 0,1,0,1,0,1; rsp_id matches order.
REQ-036 Back-pressure: rsp_ready low 10 cycles -> rsp_* stable, req1_ready stays low, no new eng_start.
REQ-037 Reset mid-RUN at cycle 5 -> eng_start low asynchronously, no rsp_valid; a following req1 op completes normally.
REQ-038 Timeout (macro defined, TIMEOUT_CYCLES=16, model never stops) -> rsp_valid with rsp_err=1, rsp_ans=0 after 16 RUN cycles; without macro -> busy remains high for 1000 cycles.
REQ-039 Stale stop: eng_stop held high at RUN entry -> no completion until it falls and rises again.

Source files
------------

// File: rtl/mon_exp_sched.sv
// Two-requester round-robin scheduler for one shared modular-exponentiation engine; watchdog via MON_EXP_SCHED_TIMEOUT_EN.
// Latency: eng_start 1 cycle after accept, rsp_valid 1 cycle after an eng_stop rising edge.
// Backpressure: response held until rsp_ready; no new request is accepted until the response drains.
`timescale 1ns/1ps
module mon_exp_sched #(
    parameter int bitLen         = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [bitLen-1:0] req0_M_bar,
    input  logic [bitLen-1:0] req0_x_bar,
    input  logic [bitLen-1:0] req0_e,
    input  logic [bitLen-1:0] req0_n,
    input  logic [bitLen-1:0] req1_M_bar,
    input  logic [bitLen-1:0] req1_x_bar,
    input  logic [bitLen-1:0] req1_e,
    input  logic [bitLen-1:0] req1_n,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [bitLen:0]   rsp_ans,
    output logic              rsp_err,
    output logic              busy,
    output logic              eng_start,
    output logic [bitLen-1:0] eng_M_bar,
    output logic [bitLen-1:0] eng_x_bar,
    output logic [bitLen-1:0] eng_e,
    output logic [bitLen-1:0] eng_n,
    input  logic              eng_stop,
    input  logic [bitLen:0]   eng_ans
);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              id_q, id_d;
    logic              start_q, start_d;
    logic              vld_q, vld_d;
    logic              err_q, err_d;
    logic              stop_prev_q;
    logic [bitLen:0]   ans_q, ans_d;
    logic [bitLen-1:0] m_q, m_d, x_q, x_d, e_q, e_d, n_q, n_d;
    logic              grant, accept, stop_rise, timeout;

`ifdef MON_EXP_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign timeout = (state_q == RUN) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // Grant points at the requester not served last when both contend.
    assign grant      = (req0_valid && req1_valid) ? ~last_q : ~req0_valid;
    assign req0_ready = rst_n && (state_q == IDLE) && req0_valid && !grant;
    assign req1_ready = rst_n && (state_q == IDLE) && req1_valid && grant;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign stop_rise  = eng_stop && !stop_prev_q;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        start_d = start_q;
        vld_d   = vld_q;
        err_d   = err_q;
        ans_d   = ans_q;
        m_d     = m_q;
        x_d     = x_q;
        e_d     = e_q;
        n_d     = n_q;
`ifdef MON_EXP_SCHED_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    id_d    = grant;
                    last_d  = grant;
                    start_d = 1'b1;
                    m_d     = grant ? req1_M_bar : req0_M_bar;
                    x_d     = grant ? req1_x_bar : req0_x_bar;
                    e_d     = grant ? req1_e     : req0_e;
                    n_d     = grant ? req1_n     : req0_n;
`ifdef MON_EXP_SCHED_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            RUN: begin
                if (stop_rise) begin
                    state_d = RESP;
                    start_d = 1'b0;
                    vld_d   = 1'b1;
                    err_d   = 1'b0;
                    ans_d   = eng_ans;
                end else if (timeout) begin
                    state_d = RESP;
                    start_d = 1'b0;
                    vld_d   = 1'b1;
                    err_d   = 1'b1;
                    ans_d   = '0;
                end else begin
`ifdef MON_EXP_SCHED_TIMEOUT_EN
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            start_q     <= 1'b0;
            vld_q       <= 1'b0;
            err_q       <= 1'b0;
            stop_prev_q <= 1'b0;
            ans_q       <= '0;
            m_q         <= '0;
            x_q         <= '0;
            e_q         <= '0;
            n_q         <= '0;
`ifdef MON_EXP_SCHED_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            start_q     <= start_d;
            vld_q       <= vld_d;
            err_q       <= err_d;
            stop_prev_q <= eng_stop;
            ans_q       <= ans_d;
            m_q         <= m_d;
            x_q         <= x_d;
            e_q         <= e_d;
            n_q         <= n_d;
`ifdef MON_EXP_SCHED_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign rsp_valid = vld_q;
    assign rsp_id    = id_q;
    assign rsp_ans   = ans_q;
    assign rsp_err   = err_q;
    assign busy      = (state_q != IDLE);
    assign eng_start = start_q;
    assign eng_M_bar = m_q;
    assign eng_x_bar = x_q;
    assign eng_e     = e_q;
    assign eng_n     = n_q;

endmodule

// File: tb/tb_mon_exp_sched.sv
// Scoreboard bench for mon_exp_sched: random and directed requests, an engine model, and a response monitor.
`timescale 1ns/1ps
module tb_mon_exp_sched;

    localparam int BL = 64;
    localparam int TO = 16;

    typedef struct packed {
        logic [BL-1:0] m;
        logic [BL-1:0] x;
        logic [BL-1:0] e;
        logic [BL-1:0] n;
    } op_t;

    typedef struct packed {
        logic          id;
        logic [BL:0]   ans;
        logic          err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          rsp_valid, rsp_id, rsp_err, busy, eng_start;
    logic          req0_ready, req1_ready;
    logic          rsp_ready = 1'b1;
    logic          eng_stop  = 1'b0;
    logic [BL:0]   rsp_ans;
    logic [BL:0]   eng_ans   = '0;
    logic [BL-1:0] eng_M_bar, eng_x_bar, eng_e, eng_n;

    bit   v[2];
    bit   junk[2];
    op_t  o[2];
    op_t  rq[2][$];
    rsp_t sb[$];
    bit   id_log[$];

    int   n_chk = 0, n_fail = 0, cyc = 0;
    int   acc_cyc = 0, stop_cyc = -1, ecnt = 0;
    int   mode = 0, dly_min = 1, dly_max = 4, max_gap = 0;
    bit   acc_pending[2];
    bit   last_m = 1'b1, m_idle = 1'b1, rv_seen = 1'b0, prev_start = 1'b0;
    bit   rnd_rdy = 1'b0, force_lo = 1'b0, exp_timeout = 1'b0, ovr_en = 1'b0;
    logic [BL:0] ovr_ans = '0;
    op_t  exp_ops;
    rsp_t held;

    mon_exp_sched #(.bitLen(BL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v[0]), .req1_valid(v[1]),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_M_bar(o[0].m), .req0_x_bar(o[0].x), .req0_e(o[0].e), .req0_n(o[0].n),
        .req1_M_bar(o[1].m), .req1_x_bar(o[1].x), .req1_e(o[1].e), .req1_n(o[1].n),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_ans(rsp_ans), .rsp_err(rsp_err), .busy(busy),
        .eng_start(eng_start), .eng_M_bar(eng_M_bar), .eng_x_bar(eng_x_bar),
        .eng_e(eng_e), .eng_n(eng_n), .eng_stop(eng_stop), .eng_ans(eng_ans)
    );

    task automatic chk(input string nm, input logic [259:0] act, input logic [259:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [BL:0] eng_fn(input op_t p);
        if (ovr_en) return ovr_ans;
        return {1'b0, p.m} + {1'b0, p.x ^ p.e} + {1'b0, p.n};
    endfunction

    function automatic op_t rnd_op();
        op_t p;
        p.m = {$urandom, $urandom};
        p.x = {$urandom, $urandom};
        p.e = {$urandom, $urandom};
        p.n = {$urandom, $urandom};
        return p;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model, engine model and response monitor share one negedge process.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_idle = 1'b1; last_m = 1'b1; rv_seen = 1'b0;
            prev_start = 1'b0; ecnt = 0; eng_stop = 1'b0;
        end else begin
            logic [1:0] er;
            bit g;
            op_t cur;
            g  = (v[0] && v[1]) ? ~last_m : ~v[0];
            er = 2'b00;
            if (m_idle && (v[0] || v[1])) er[g] = 1'b1;
            chk("ready", {req1_ready, req0_ready}, er);
            chk("busy", busy, !m_idle);
            if (er != 2'b00) begin
                acc_pending[g] = 1'b1;
                last_m  = g;
                m_idle  = 1'b0;
                exp_ops = o[g];
                acc_cyc = cyc + 1;
                if (exp_timeout) begin
                    sb.push_back('{id: g, ans: '0, err: 1'b1});
                    stop_cyc = acc_cyc + TO;
                end else begin
                    sb.push_back('{id: g, ans: eng_fn(o[g]), err: 1'b0});
                end
            end

            cur = '{m: eng_M_bar, x: eng_x_bar, e: eng_e, n: eng_n};
            if (eng_start && !prev_start) begin
                chk("start_lat", cyc, acc_cyc);
                chk("eng_ops", cur, exp_ops);
            end
            case (mode)
                0: begin
                    eng_stop = 1'b0;
                    if (eng_start && !prev_start) ecnt = $urandom_range(dly_max, dly_min);
                    else if (eng_start && ecnt > 0) begin
                        ecnt--;
                        if (ecnt == 0) begin
                            eng_stop = 1'b1; eng_ans = eng_fn(cur); stop_cyc = cyc + 1;
                        end
                    end
                end
                1: eng_stop = 1'b0;
                default: begin
                    if (eng_start && !prev_start) begin ecnt = 0; stop_cyc = -1; end
                    if (eng_start) begin
                        ecnt++;
                        if (ecnt == 4) eng_stop = 1'b0;
                        if (ecnt == 6) begin
                            eng_stop = 1'b1; eng_ans = eng_fn(cur); stop_cyc = cyc + 1;
                        end
                    end else eng_stop = 1'b1;
                end
            endcase
            prev_start = eng_start;

            if (rsp_valid) begin
                if (!rv_seen) begin
                    rv_seen = 1'b1;
                    chk("rsp_lat", cyc, stop_cyc);
                    held = '{id: rsp_id, ans: rsp_ans, err: rsp_err};
                end else begin
                    chk("rsp_hold", {rsp_id, rsp_ans, rsp_err}, held);
                end
                if (rsp_ready) begin
                    if (sb.size() == 0) chk("sb_nonempty", sb.size(), 1);
                    else chk("rsp", {rsp_id, rsp_ans, rsp_err}, sb.pop_front());
                    chk("ops_held", cur, exp_ops);
                    id_log.push_back(rsp_id);
                    rv_seen = 1'b0;
                    m_idle  = 1'b1;
                end
            end
        end
    end

    task automatic drive(input int i);
        int gap = 0;
        forever begin
            @(posedge clk); #1;
            if (acc_pending[i]) begin
                acc_pending[i] = 1'b0;
                if (rq[i].size() > 0) void'(rq[i].pop_front());
                v[i] = 1'b0;
                gap  = $urandom_range(max_gap, 0);
            end
            if (junk[i]) begin v[i] = 1'b0; junk[i] = 1'b0; end
            if (!rst_n) v[i] = 1'b0;
            else if (!v[i]) begin
                if (rq[i].size() > 0) begin
                    if (gap > 0) gap--;
                    else begin v[i] = 1'b1; o[i] = rq[i][0]; end
                end else if (busy && max_gap > 0 && $urandom_range(5, 0) == 0) begin
                    junk[i] = 1'b1; v[i] = 1'b1; o[i] = rnd_op();
                end
            end
        end
    endtask

    initial drive(0);
    initial drive(1);
    initial forever begin
        @(posedge clk); #1;
        rsp_ready = force_lo ? 1'b0 : (rnd_rdy ? ($urandom_range(2, 0) != 0) : 1'b1);
    end

    task automatic wait_idle(input int lim, input string nm);
        int k = 0;
        while ((sb.size() > 0 || rq[0].size() > 0 || rq[1].size() > 0 || busy) && k < lim) begin
            @(negedge clk); k++;
        end
        if (k >= lim) begin
            n_chk++; n_fail++;
            $display("FAIL %s: still busy after %0d cycles", nm, lim);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete(); rq[0].delete(); rq[1].delete();
        acc_pending[0] = 1'b0; acc_pending[1] = 1'b0;
        v[0] = 1'b0; v[1] = 1'b0; junk[0] = 1'b0; junk[1] = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        op_t p;
        int k;
        #1 rst_n = 1'b0;
        v[0] = 1'b1;
        #20;
        chk("rst_eng_start", eng_start, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_rsp_id_ans", {rsp_id, rsp_ans}, 0);
        chk("rst_eng_ops", {eng_M_bar, eng_x_bar, eng_e, eng_n}, 0);
        v[0] = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;

        // Contention: three ops queued on each requester at once.
        id_log.delete();
        for (int i = 0; i < 3; i++) begin rq[0].push_back(rnd_op()); rq[1].push_back(rnd_op()); end
        wait_idle(2000, "contention");
        chk("rr_count", id_log.size(), 6);
        for (int i = 0; i < 6 && i < id_log.size(); i++) chk("rr_order", id_log[i], i % 2);

        // Single op with a fixed engine answer and 20-cycle engine delay.
        ovr_en = 1'b1; ovr_ans = 311; dly_min = 20; dly_max = 20;
        p = '{m: 26, x: 157, e: 5, n: 589};
        rq[0].push_back(p);
        wait_idle(500, "single_op");
        ovr_en = 1'b0; dly_min = 1; dly_max = 4;

        // Back-pressure while requester 1 waits.
        force_lo = 1'b1;
        rq[0].push_back(rnd_op());
        k = 0;
        while (!rsp_valid && k < 200) begin @(negedge clk); k++; end
        if (k >= 200) begin n_chk++; n_fail++; $display("FAIL bp_wait: no rsp_valid"); end
        rq[1].push_back(rnd_op());
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_req1_ready", req1_ready, 0);
            chk("bp_eng_start", eng_start, 0);
        end
        force_lo = 1'b0;
        wait_idle(500, "backpressure");

        // Reset in the middle of a run.
        dly_min = 30; dly_max = 30;
        rq[0].push_back(rnd_op());
        k = 0;
        while (!eng_start && k < 200) begin @(negedge clk); k++; end
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_eng_start", eng_start, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        #1 do_reset();
        dly_min = 1; dly_max = 4;
        rq[1].push_back(rnd_op());
        wait_idle(500, "after_reset");

        // eng_stop already high at run entry.
        mode = 2;
        repeat (3) @(negedge clk);
        rq[0].push_back(rnd_op());
        wait_idle(500, "stale_stop");
        mode = 0;
        repeat (2) @(negedge clk);

        // Randomised traffic.
        rnd_rdy = 1'b1; max_gap = 3; dly_min = 1; dly_max = 6;
        for (int i = 0; i < 40; i++) begin
            rq[$urandom_range(1, 0)].push_back(rnd_op());
            repeat ($urandom_range(10, 0)) @(negedge clk);
        end
        wait_idle(8000, "random");
        rnd_rdy = 1'b0; max_gap = 0;

        // Engine that never finishes.
        mode = 1;
`ifdef MON_EXP_SCHED_TIMEOUT_EN
        exp_timeout = 1'b1;
        rq[1].push_back(rnd_op());
        wait_idle(500, "timeout");
        exp_timeout = 1'b0;
`else
        rq[1].push_back(rnd_op());
        repeat (1000) @(negedge clk);
        chk("hang_busy", busy, 1);
        chk("hang_rsp_valid", rsp_valid, 0);
        do_reset();
`endif
        mode = 0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
